// File: rtl/npc_redirect.sv
// Next-PC generator for fetch: PC+4 sequencing, decode redirects, and buffering
// of redirects that arrive while fetch is stalled.
module npc_redirect #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          MASK_LOW = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stop_F,
   input  logic [31:0] PC_F,
   input  logic        br_valid,
   input  logic [1:0]  br_type,
   input  logic [31:0] br_pc,
   input  logic [25:0] br_imm,
   input  logic [31:0] br_reg,
   output logic [31:0] Addr_F_Out,
   output logic        redirect_pending,
   output logic        err_misaligned,
   output logic        err_protocol
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      BR_REL = 2'b00,
      BR_ABS = 2'b01,
      BR_REG = 2'b10,
      BR_RSV = 2'b11
   } br_type_t;

   state_t      state_q, state_d;
   logic [31:0] hold_tgt_q, hold_tgt_d;
   logic        err_protocol_q, err_protocol_d;
   logic        err_misaligned_q, err_misaligned_d;

   logic [31:0] br_pc_plus4;
   logic [31:0] br_offset;
   logic [31:0] target;
   logic        br_ok;
   logic        br_rsv;

   function automatic logic [31:0] mask_tgt(input logic [31:0] t);
      if (MASK_LOW != 0) begin
         return {t[31:2], 2'b00};
      end
      return t;
   endfunction

   assign br_pc_plus4 = br_pc + 32'd4;
   assign br_offset   = {{14{br_imm[15]}}, br_imm[15:0], 2'b00};
   assign br_ok       = br_valid && (br_type_t'(br_type) != BR_RSV);
   assign br_rsv      = br_valid && (br_type_t'(br_type) == BR_RSV);

   always_comb begin
      target = '0;
      case (br_type_t'(br_type))
         BR_REL:  target = br_pc_plus4 + br_offset;
         BR_ABS:  target = {br_pc_plus4[31:28], br_imm[25:0], 2'b00};
         BR_REG:  target = br_reg;
         default: target = '0;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      hold_tgt_d       = hold_tgt_q;
      err_protocol_d   = err_protocol_q;
      err_misaligned_d = 1'b0;
      Addr_F_Out       = PC_F + 32'd4;
      redirect_pending = 1'b0;

      if (reset) begin
         Addr_F_Out = RESET_PC;
      end else begin
         case (state_q)
            IDLE: begin
               if (br_ok && !Stop_F) begin
                  Addr_F_Out = mask_tgt(target);
               end else if (Stop_F) begin
                  Addr_F_Out = PC_F;
               end
               if (br_ok && Stop_F) begin
                  state_d    = HOLD;
                  hold_tgt_d = target;
               end
            end
            HOLD: begin
               redirect_pending = 1'b1;
               Addr_F_Out       = mask_tgt(hold_tgt_q);
               // A second redirect while buffering is illegal; latest target wins.
               if (br_ok) begin
                  hold_tgt_d     = target;
                  err_protocol_d = 1'b1;
               end
               if (!Stop_F) begin
                  state_d = IDLE;
                  if (br_ok) begin
                     Addr_F_Out = mask_tgt(target);
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (br_rsv) begin
            err_protocol_d = 1'b1;
         end
         if (br_ok && (target[1:0] != 2'b00)) begin
            err_misaligned_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         hold_tgt_q       <= '0;
         err_protocol_q   <= 1'b0;
         err_misaligned_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         hold_tgt_q       <= hold_tgt_d;
         err_protocol_q   <= err_protocol_d;
         err_misaligned_q <= err_misaligned_d;
      end
   end

   assign err_protocol   = err_protocol_q;
   assign err_misaligned = err_misaligned_q;

endmodule

// File: tb/tb_npc_redirect.sv
// Directed bench for npc_redirect: sequencing, target arithmetic, stall buffering,
// overwrite/reserved protocol errors and reset while holding.
module tb_npc_redirect;

   logic        clk;
   logic        reset;
   logic        Stop_F;
   logic [31:0] PC_F;
   logic        br_valid;
   logic [1:0]  br_type;
   logic [31:0] br_pc;
   logic [25:0] br_imm;
   logic [31:0] br_reg;
   logic [31:0] Addr_F_Out;
   logic        redirect_pending;
   logic        err_misaligned;
   logic        err_protocol;

   int unsigned checks = 0;
   int unsigned errors = 0;

   npc_redirect #(
      .RESET_PC (32'h0000_3000),
      .MASK_LOW (1)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .Stop_F           (Stop_F),
      .PC_F             (PC_F),
      .br_valid         (br_valid),
      .br_type          (br_type),
      .br_pc            (br_pc),
      .br_imm           (br_imm),
      .br_reg           (br_reg),
      .Addr_F_Out       (Addr_F_Out),
      .redirect_pending (redirect_pending),
      .err_misaligned   (err_misaligned),
      .err_protocol     (err_protocol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; outputs sampled 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] pc,
                        input logic [25:0] imm, input logic [31:0] r);
      br_valid = v;
      br_type  = t;
      br_pc    = pc;
      br_imm   = imm;
      br_reg   = r;
   endtask

   initial begin
      reset  = 1'b1;
      Stop_F = 1'b0;
      PC_F   = 32'h0000_3000;
      drive(1'b0, 2'b00, '0, '0, '0);
      tick();

      // reset: RESET_PC presented, redirect ignored
      #1;
      chk("rst_addr", Addr_F_Out, 32'h0000_3000);
      chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
      tick();
      drive(1'b1, 2'b10, '0, '0, 32'h0000_1236);
      #1;
      chk("rst_br_ignored", Addr_F_Out, 32'h0000_3000);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("rst_errm", {31'd0, err_misaligned}, 32'd0);
      chk("rst_errp", {31'd0, err_protocol}, 32'd0);

      // release: PC+4
      reset = 1'b0;
      #1;
      chk("seq_pc4", Addr_F_Out, 32'h0000_3004);
      chk("seq_pend", {31'd0, redirect_pending}, 32'd0);

      // PC-relative branches
      tick();
      drive(1'b1, 2'b00, 32'h0000_3008, 26'h000_FFFE, '0);
      #1;
      chk("rel_neg", Addr_F_Out, 32'h0000_3004);
      tick();
      drive(1'b1, 2'b00, 32'h0000_3008, 26'h000_0010, '0);
      #1;
      chk("rel_pos", Addr_F_Out, 32'h0000_304C);
      chk("rel_idle", {31'd0, redirect_pending}, 32'd0);
      tick();
      drive(1'b1, 2'b00, 32'hFFFF_FFF8, 26'h000_0002, '0);
      #1;
      chk("rel_wrap", Addr_F_Out, 32'h0000_0004);

      // absolute jumps
      tick();
      drive(1'b1, 2'b01, 32'h0000_3010, 26'h000_0C10, '0);
      #1;
      chk("abs_basic", Addr_F_Out, 32'h0000_3040);
      tick();
      drive(1'b1, 2'b01, 32'hA000_0000, 26'h3FF_FFFF, '0);
      #1;
      chk("abs_region", Addr_F_Out, 32'hAFFF_FFFC);
      tick();
      drive(1'b1, 2'b01, 32'h0FFF_FFFC, 26'h000_0010, '0);
      #1;
      chk("abs_carry", Addr_F_Out, 32'h1000_0040);

      // register jump, misaligned target masked, error pulse next cycle
      tick();
      drive(1'b1, 2'b10, '0, '0, 32'h0000_3022);
      #1;
      chk("reg_mask", Addr_F_Out, 32'h0000_3020);
      chk("reg_errm_pre", {31'd0, err_misaligned}, 32'd0);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("reg_errm_pulse", {31'd0, err_misaligned}, 32'd1);
      tick();
      #1;
      chk("reg_errm_clear", {31'd0, err_misaligned}, 32'd0);

      // stall buffering
      PC_F   = 32'h0000_3100;
      Stop_F = 1'b1;
      drive(1'b1, 2'b10, '0, '0, 32'h0000_4000);
      #1;
      chk("stall_pc", Addr_F_Out, 32'h0000_3100);
      chk("stall_pend0", {31'd0, redirect_pending}, 32'd0);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("hold1_addr", Addr_F_Out, 32'h0000_4000);
      chk("hold1_pend", {31'd0, redirect_pending}, 32'd1);
      tick();
      #1;
      chk("hold2_addr", Addr_F_Out, 32'h0000_4000);
      chk("hold2_pend", {31'd0, redirect_pending}, 32'd1);
      tick();
      Stop_F = 1'b0;
      #1;
      chk("release_addr", Addr_F_Out, 32'h0000_4000);
      tick();
      PC_F = 32'h0000_4000;
      #1;
      chk("after_addr", Addr_F_Out, 32'h0000_4004);
      chk("after_pend", {31'd0, redirect_pending}, 32'd0);
      chk("after_errp", {31'd0, err_protocol}, 32'd0);

      // overwrite while holding
      tick();
      PC_F   = 32'h0000_4004;
      Stop_F = 1'b1;
      drive(1'b1, 2'b10, '0, '0, 32'h0000_4000);
      tick();
      drive(1'b1, 2'b10, '0, '0, 32'h0000_5000);
      #1;
      chk("ovw_old", Addr_F_Out, 32'h0000_4000);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("ovw_new", Addr_F_Out, 32'h0000_5000);
      chk("ovw_errp", {31'd0, err_protocol}, 32'd1);
      tick();
      Stop_F = 1'b0;
      #1;
      chk("ovw_release", Addr_F_Out, 32'h0000_5000);
      tick();
      PC_F = 32'h0000_5000;
      #1;
      chk("ovw_after", Addr_F_Out, 32'h0000_5004);
      chk("ovw_sticky", {31'd0, err_protocol}, 32'd1);

      // overwrite in HOLD on the release cycle: new target goes out directly
      Stop_F = 1'b1;
      drive(1'b1, 2'b10, '0, '0, 32'h0000_6000);
      tick();
      Stop_F = 1'b0;
      drive(1'b1, 2'b10, '0, '0, 32'h0000_7000);
      #1;
      chk("ovw_rel_addr", Addr_F_Out, 32'h0000_7000);
      tick();
      PC_F = 32'h0000_7000;
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("ovw_rel_idle", {31'd0, redirect_pending}, 32'd0);
      chk("ovw_rel_pc4", Addr_F_Out, 32'h0000_7004);

      // reset while holding discards buffered target
      Stop_F = 1'b1;
      drive(1'b1, 2'b10, '0, '0, 32'h0000_4000);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("prerst_pend", {31'd0, redirect_pending}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_addr", Addr_F_Out, 32'h0000_3000);
      chk("midrst_pend", {31'd0, redirect_pending}, 32'd0);
      tick();
      reset  = 1'b0;
      Stop_F = 1'b0;
      PC_F   = 32'h0000_3000;
      #1;
      chk("postrst_addr", Addr_F_Out, 32'h0000_3004);
      chk("postrst_pend", {31'd0, redirect_pending}, 32'd0);
      chk("postrst_errp", {31'd0, err_protocol}, 32'd0);

      // reserved type: error flag only
      drive(1'b1, 2'b11, 32'h0000_3000, 26'h000_0040, 32'h0000_8003);
      #1;
      chk("rsv_addr", Addr_F_Out, 32'h0000_3004);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      #1;
      chk("rsv_errp", {31'd0, err_protocol}, 32'd1);
      chk("rsv_errm", {31'd0, err_misaligned}, 32'd0);
      chk("rsv_pend", {31'd0, redirect_pending}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
